// File: rtl/mem_issue_queue_if.sv
// rtl/mem_issue_queue_if.sv - dispatch, CDB, FU and issue signal bundle for the memory issue queue
//
// Signals:
//   flush                          discard all queued ops
//   disp_valid/robid/operand/      op offered by dispatch; dep_ready/dep_tag/depvals
//   flags/wbs/dep_ready/dep_tag/     index [1] = address A, [0] = data B
//   depvals
//   full                           queue cannot accept dispatch
//   cdb_valid/cdb_id/cdb_val       common data bus broadcast
//   fu_busy                        RAM functional unit stall
//   issue_transmit/robid/operand/  op presented to the RAM FU (one-cycle pulse)
//   flags/wbs/depvals
// Modports: master = surrounding pipeline, slave = queue.
interface mem_issue_queue_if;
  logic            flush;
  logic            disp_valid;
  logic [3:0]      disp_robid;
  logic [7:0]      disp_operand;
  logic [7:0]      disp_flags;
  logic [7:0]      disp_wbs;
  logic [1:0]      disp_dep_ready;
  logic [1:0][3:0] disp_dep_tag;
  logic [1:0][7:0] disp_depvals;
  logic            full;
  logic            cdb_valid;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            fu_busy;
  logic            issue_transmit;
  logic [3:0]      issue_robid;
  logic [7:0]      issue_operand;
  logic [7:0]      issue_flags;
  logic [7:0]      issue_wbs;
  logic [1:0][7:0] issue_depvals;

  modport master (
    output flush, disp_valid, disp_robid, disp_operand, disp_flags, disp_wbs,
           disp_dep_ready, disp_dep_tag, disp_depvals, cdb_valid, cdb_id, cdb_val, fu_busy,
    input  full, issue_transmit, issue_robid, issue_operand, issue_flags, issue_wbs,
           issue_depvals
  );

  modport slave (
    input  flush, disp_valid, disp_robid, disp_operand, disp_flags, disp_wbs,
           disp_dep_ready, disp_dep_tag, disp_depvals, cdb_valid, cdb_id, cdb_val, fu_busy,
    output full, issue_transmit, issue_robid, issue_operand, issue_flags, issue_wbs,
           issue_depvals
  );
endinterface

// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order memory op issue queue with CDB operand snooping
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   o_stall_cnt  saturating count of cycles a ready head was held by fu_busy
//                (present only when MEMQ_STALL_CNT_EN is defined)
//   io           mem_issue_queue_if.slave: dispatch, CDB, FU stall and issue signals
module mem_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef MEMQ_STALL_CNT_EN
  output logic [15:0]           o_stall_cnt,
`endif
  mem_issue_queue_if.slave      io
);
  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W:0]  r_head;
  logic [PTR_W:0]  r_tail;
  logic [DEPTH-1:0] r_valid;
  logic [3:0]      r_robid   [DEPTH];
  logic [7:0]      r_operand [DEPTH];
  logic [7:0]      r_flags   [DEPTH];
  logic [7:0]      r_wbs     [DEPTH];
  logic [1:0]      r_rdy     [DEPTH];
  logic [1:0][3:0] r_tag     [DEPTH];
  logic [1:0][7:0] r_val     [DEPTH];

  logic            r_issue_transmit;
  logic [3:0]      r_issue_robid;
  logic [7:0]      r_issue_operand;
  logic [7:0]      r_issue_flags;
  logic [7:0]      r_issue_wbs;
  logic [1:0][7:0] r_issue_depvals;

  logic [PTR_W-1:0] w_head_idx;
  logic [PTR_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_disp_acc;
  logic             w_head_ready;
  logic             w_issue;
  logic [1:0]       w_disp_rdy;
  logic [1:0][7:0]  w_disp_val;

  assign w_head_idx = r_head[PTR_W-1:0];
  assign w_tail_idx = r_tail[PTR_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PTR_W] != r_tail[PTR_W]);
  assign w_disp_acc = io.disp_valid && !w_full;

  // Readiness comes from registered bits only, so a head woken by the CDB
  // this cycle issues no earlier than next cycle.
  assign w_head_ready = r_valid[w_head_idx] && (&r_rdy[w_head_idx]);
  assign w_issue      = w_head_ready && !io.fu_busy;

  // An op entering the queue also catches a broadcast on the same cycle.
  always_comb begin
    w_disp_rdy = '0;
    w_disp_val = io.disp_depvals;
    for (int k = 0; k < 2; k++) begin
      if (io.disp_dep_ready[k]) begin
        w_disp_rdy[k] = 1'b1;
      end else if (io.cdb_valid && (io.disp_dep_tag[k] == io.cdb_id)) begin
        w_disp_rdy[k] = 1'b1;
        w_disp_val[k] = io.cdb_val;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || io.flush) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_valid          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdy[i] <= '0;
      end
      r_issue_transmit <= 1'b0;
      r_issue_robid    <= '0;
      r_issue_operand  <= '0;
      r_issue_flags    <= '0;
      r_issue_wbs      <= '0;
      r_issue_depvals  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < 2; k++) begin
          if (io.cdb_valid && r_valid[i] && !r_rdy[i][k] && (r_tag[i][k] == io.cdb_id)) begin
            r_rdy[i][k] <= 1'b1;
            r_val[i][k] <= io.cdb_val;
          end
        end
      end

      r_issue_transmit <= w_issue;
      if (w_issue) begin
        r_issue_robid       <= r_robid[w_head_idx];
        r_issue_operand     <= r_operand[w_head_idx];
        r_issue_flags       <= r_flags[w_head_idx];
        r_issue_wbs         <= r_wbs[w_head_idx];
        r_issue_depvals     <= r_val[w_head_idx];
        r_valid[w_head_idx] <= 1'b0;
        r_head              <= r_head + (PTR_W+1)'(1);
      end

      // Full is judged on registered pointers, so a slot freed by this
      // cycle's issue cannot be refilled until the next cycle.
      if (w_disp_acc) begin
        r_valid[w_tail_idx]   <= 1'b1;
        r_robid[w_tail_idx]   <= io.disp_robid;
        r_operand[w_tail_idx] <= io.disp_operand;
        r_flags[w_tail_idx]   <= io.disp_flags;
        r_wbs[w_tail_idx]     <= io.disp_wbs;
        r_rdy[w_tail_idx]     <= w_disp_rdy;
        r_tag[w_tail_idx]     <= io.disp_dep_tag;
        r_val[w_tail_idx]     <= w_disp_val;
        r_tail                <= r_tail + (PTR_W+1)'(1);
      end
    end
  end

`ifdef MEMQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Survives flush so stall history spans misprediction recovery.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_head_ready && io.fu_busy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign io.full           = w_full;
  assign io.issue_transmit = r_issue_transmit;
  assign io.issue_robid    = r_issue_robid;
  assign io.issue_operand  = r_issue_operand;
  assign io.issue_flags    = r_issue_flags;
  assign io.issue_wbs      = r_issue_wbs;
  assign io.issue_depvals  = r_issue_depvals;
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb/tb_mem_issue_queue.sv - scoreboard bench for mem_issue_queue
module tb_mem_issue_queue;
  logic clk;
  logic rst;
`ifdef MEMQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  mem_issue_queue_if bus ();

  mem_issue_queue #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef MEMQ_STALL_CNT_EN
    .o_stall_cnt (stall_cnt),
`endif
    .io          (bus)
  );

  typedef struct packed {
    logic [3:0]  robid;
    logic [7:0]  operand;
    logic [7:0]  flags;
    logic [7:0]  wbs;
    logic [15:0] dv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_issued = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] robid, input logic [7:0] flags,
                          input logic [1:0] rdy, input logic [3:0] tag_a,
                          input logic [3:0] tag_d, input logic [7:0] val_a,
                          input logic [7:0] val_d, input logic [7:0] exp_a,
                          input logic [7:0] exp_d, input bit accept);
    exp_t e;
    bus.disp_valid      = 1'b1;
    bus.disp_robid      = robid;
    bus.disp_operand    = {4'hA, robid};
    bus.disp_flags      = flags;
    bus.disp_wbs        = {robid, 4'h5};
    bus.disp_dep_ready  = rdy;
    bus.disp_dep_tag[1] = tag_a;
    bus.disp_dep_tag[0] = tag_d;
    bus.disp_depvals[1] = val_a;
    bus.disp_depvals[0] = val_d;
    if (accept) begin
      e.robid   = robid;
      e.operand = {4'hA, robid};
      e.flags   = flags;
      e.wbs     = {robid, 4'h5};
      e.dv      = {exp_a, exp_d};
      sb.push_back(e);
    end
    cyc();
    bus.disp_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = id;
    bus.cdb_val   = val;
    cyc();
    bus.cdb_valid = 1'b0;
  endtask

  // Every issue pulse is matched against the oldest expected op.
  always @(negedge clk) begin
    if (!rst && bus.issue_transmit) begin
      n_issued++;
      if (sb.size() == 0) begin
        chk("unexpected_issue", 32'(bus.issue_robid), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_robid",   32'(bus.issue_robid),   32'(e.robid));
        chk("iss_operand", 32'(bus.issue_operand), 32'(e.operand));
        chk("iss_flags",   32'(bus.issue_flags),   32'(e.flags));
        chk("iss_wbs",     32'(bus.issue_wbs),     32'(e.wbs));
        chk("iss_depvals", 32'(bus.issue_depvals), 32'(e.dv));
      end
    end
  end

  initial begin
    #200000;
    chk("timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_robid = '0;
    bus.disp_operand = '0;
    bus.disp_flags = '0;
    bus.disp_wbs = '0;
    bus.disp_dep_ready = '0;
    bus.disp_dep_tag = '0;
    bus.disp_depvals = '0;
    bus.cdb_valid = 1'b0;
    bus.cdb_id = '0;
    bus.cdb_val = '0;
    bus.fu_busy = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    chk("rst_full",  32'(bus.full), 0);
    chk("rst_tx",    32'(bus.issue_transmit), 0);
    chk("rst_robid", 32'(bus.issue_robid), 0);
    chk("rst_dv",    32'(bus.issue_depvals), 0);
`ifdef MEMQ_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cnt), 0);
`endif

    // Ready load: two-cycle latency, single-cycle pulse.
    dispatch(4'd3, 8'h00, 2'b11, 4'd0, 4'd0, 8'h10, 8'h01, 8'h10, 8'h01, 1);
    chk("t1_lat0", 32'(bus.issue_transmit), 0);
    cyc();
    chk("t1_tx", 32'(bus.issue_transmit), 1);
    chk("t1_robid", 32'(bus.issue_robid), 3);
    chk("t1_addr", 32'(bus.issue_depvals[1]), 32'h10);
    cyc();
    chk("t1_pulse", 32'(bus.issue_transmit), 0);

    // Waiting store blocks a ready younger load.
    dispatch(4'd1, 8'h02, 2'b01, 4'd5, 4'd0, 8'hEE, 8'h33, 8'h20, 8'h33, 1);
    dispatch(4'd2, 8'h00, 2'b11, 4'd0, 4'd0, 8'h44, 8'h00, 8'h44, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_blocked", 32'(bus.issue_transmit), 0);
    end
    cdb(4'd5, 8'h20);
    chk("t2_wake_noissue", 32'(bus.issue_transmit), 0);
    cyc();
    chk("t2_st_tx", 32'(bus.issue_transmit), 1);
    chk("t2_st_robid", 32'(bus.issue_robid), 1);
    chk("t2_st_addr", 32'(bus.issue_depvals[1]), 32'h20);
    cyc();
    chk("t2_ld_tx", 32'(bus.issue_transmit), 1);
    chk("t2_ld_robid", 32'(bus.issue_robid), 2);
    cyc();
    chk("t2_idle", 32'(bus.issue_transmit), 0);

    // Full: four ops on tag 9, fifth dropped, then in-order drain.
    dispatch(4'd4, 8'h02, 2'b01, 4'd9, 4'd0, 8'hEE, 8'h44, 8'h99, 8'h44, 1);
    dispatch(4'd5, 8'h00, 2'b00, 4'd9, 4'd9, 8'hEE, 8'hEE, 8'h99, 8'h99, 1);
    dispatch(4'd6, 8'h02, 2'b01, 4'd9, 4'd0, 8'hEE, 8'h46, 8'h99, 8'h46, 1);
    chk("t3_not_full", 32'(bus.full), 0);
    dispatch(4'd7, 8'h00, 2'b01, 4'd9, 4'd0, 8'hEE, 8'h47, 8'h99, 8'h47, 1);
    chk("t3_full", 32'(bus.full), 1);
    dispatch(4'd8, 8'h00, 2'b11, 4'd0, 4'd0, 8'h58, 8'h85, 8'h58, 8'h85, 0);
    chk("t3_still_full", 32'(bus.full), 1);
    chk("t3_no_issue", 32'(bus.issue_transmit), 0);
    cdb(4'd9, 8'h99);
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("t3_tx", 32'(bus.issue_transmit), 1);
      chk("t3_robid", 32'(bus.issue_robid), 32'(4 + j));
      if (j == 0) chk("t3_full_fall", 32'(bus.full), 0);
    end
    cyc();
    chk("t3_drained", 32'(bus.issue_transmit), 0);

    // Dispatch-cycle snoop: both operands pick up the same broadcast.
    bus.cdb_valid = 1'b1;
    bus.cdb_id = 4'd7;
    bus.cdb_val = 8'hAA;
    dispatch(4'd10, 8'h00, 2'b00, 4'd7, 4'd7, 8'hEE, 8'hEE, 8'hAA, 8'hAA, 1);
    bus.cdb_valid = 1'b0;
    cyc();
    chk("t4_tx", 32'(bus.issue_transmit), 1);
    chk("t4_addr", 32'(bus.issue_depvals[1]), 32'hAA);
    cyc();
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // Stall then flush (flush also wins over the issue fu_busy=0 would allow).
    bus.fu_busy = 1'b1;
    base = n_issued;
    dispatch(4'd11, 8'h00, 2'b11, 4'd0, 4'd0, 8'h11, 8'h22, 8'h11, 8'h22, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t5_stalled", 32'(bus.issue_transmit), 0);
    end
`ifdef MEMQ_STALL_CNT_EN
    chk("t5_stall_cnt", 32'(stall_cnt), 10);
`endif
    bus.flush = 1'b1;
    bus.fu_busy = 1'b0;
    sb.delete();
    cyc();
    bus.flush = 1'b0;
    chk("t5_full", 32'(bus.full), 0);
    chk("t5_tx", 32'(bus.issue_transmit), 0);
    chk("t5_robid_clr", 32'(bus.issue_robid), 0);
`ifdef MEMQ_STALL_CNT_EN
    chk("t5_stall_keep", 32'(stall_cnt), 10);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t5_no_issue", 32'(bus.issue_transmit), 0);
    end
    chk("t5_issue_count", 32'(n_issued - base), 0);

    // Reset mid-stream with three waiting entries.
    dispatch(4'd13, 8'h00, 2'b11, 4'd0, 4'd0, 8'h13, 8'h31, 8'h13, 8'h31, 1);
    dispatch(4'd14, 8'h02, 2'b01, 4'd12, 4'd0, 8'hEE, 8'h4E, 8'hCC, 8'h4E, 1);
    dispatch(4'd15, 8'h00, 2'b01, 4'd12, 4'd0, 8'hEE, 8'h4F, 8'hCC, 8'h4F, 1);
    dispatch(4'd0, 8'h02, 2'b01, 4'd12, 4'd0, 8'hEE, 8'h40, 8'hCC, 8'h40, 1);
    chk("t6_pre_robid", 32'(bus.issue_robid), 13);
    rst = 1'b1;
    sb.delete();
    cyc();
    rst = 1'b0;
    chk("t6_full", 32'(bus.full), 0);
    chk("t6_tx", 32'(bus.issue_transmit), 0);
    chk("t6_robid", 32'(bus.issue_robid), 0);
    chk("t6_operand", 32'(bus.issue_operand), 0);
    chk("t6_wbs", 32'(bus.issue_wbs), 0);
    chk("t6_dv", 32'(bus.issue_depvals), 0);
`ifdef MEMQ_STALL_CNT_EN
    chk("t6_stall", 32'(stall_cnt), 0);
`endif
    base = n_issued;
    cdb(4'd12, 8'hCC);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6_empty", 32'(bus.issue_transmit), 0);
    end
    chk("t6_issue_count", 32'(n_issued - base), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order issue queue that sequences memory ops (loads and stores) into the RAM functional unit.
- Buffers dispatched ops and snoops the CDB to capture missing operands.
- Issues the oldest op only, and only when both operands are ready and the FU is not busy. This keeps RAM reads and writes in program order.
- Sits between dispatch/rename and the RAM FU input port.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all queued ops (misprediction recovery)
- disp_valid  input  1  dispatch offers an op this cycle
- disp_robid  input  4  ROB id of op
- disp_operand  input  8  instruction operand field
- disp_flags  input  8  flags; bit1 set = store (B -> RAM[A]), clear = load (RAM[A] -> C)
- disp_wbs  input  8  writeback select
- disp_dep_ready  input  2  per-operand ready; [1] = address A, [0] = data B
- disp_dep_tag  input  2x4  ROB tag producing each not-ready operand
- disp_depvals  input  2x8  operand values, valid where ready
- full  output  1  queue full; dispatch must not be accepted
- cdb_valid  input  1  CDB broadcast valid
- cdb_id  input  4  CDB ROB tag
- cdb_val  input  8  CDB value
- fu_busy  input  1  RAM FU stall
- issue_transmit  output  1  one-cycle pulse: op presented to FU
- issue_robid  output  4  issued ROB id
- issue_operand  output  8  issued operand
- issue_flags  output  8  issued flags
- issue_wbs  output  8  issued wbs
- issue_depvals  output  2x8  issued operand values; [1] = address, [0] = data

Behaviour:
- **Storage:** circular buffer with head and tail pointers of PTR_W+1 bits; the extra MSB is the wrap bit.
  - full = pointers equal in index, MSBs differ.
  - empty = pointers equal, MSBs equal.
  - full is computed from registered state only.
- **Reset/flush:** on rst or flush at an edge:
  - head = tail = 0; all entry valid bits cleared; all operand-ready bits cleared.
  - issue_transmit = 0; all issue_* data outputs = 0.
  - rst has priority; flush overrides a same-cycle dispatch or issue.
- **Dispatch:** accepted when disp_valid && !full.
  - Entry is written at tail; tail increments, wrapping modulo DEPTH.
  - disp_valid while full is ignored; there is no error output.
  - A slot freed by an issue in the same cycle is not reusable that cycle.
- **CDB snoop:** every cycle with cdb_valid:
  - Each valid entry operand with ready=0 and tag==cdb_id captures cdb_val and sets ready=1.
  - The op being dispatched is also compared against the current CDB: a not-ready operand whose tag matches is written as ready with cdb_val.
  - Both operands of one entry may capture the same broadcast.
- **Issue condition:** head entry valid && both operands ready && !fu_busy.
  - On the next edge: issue_transmit=1, issue_* = head fields; head increments.
  - Otherwise issue_transmit=0 and issue_* hold their last values.
  - At most one issue per cycle.
- **Ordering:** strictly in order. A ready younger entry never issues past a not-ready head; this holds for loads and stores alike.
- **Latency:** op dispatched ready at edge k → issue_transmit high in the cycle after edge k+1 (2 cycles), provided it is at head and fu_busy=0.
- **Simultaneous events:**
  - Dispatch and issue in one cycle: both occur; occupancy unchanged.
  - CDB wakeup of the head and issue of the head in the same cycle: no issue that cycle; the op issues next cycle at the earliest.
- **Backpressure:** fu_busy held high indefinitely keeps the head in place and all issue_transmit=0; CDB snooping continues.

Optional Feature:
- Macro: MEMQ_STALL_CNT_EN.
- When defined: adds output stall_cnt (16 bits). It increments, saturating at 16'hFFFF, on every cycle where the head is valid, both its operands are ready, and fu_busy=1. It is cleared by rst only (not by flush).
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- **Ready load:** dispatch load robid=3, deps ready, A=8'h10, fu_busy=0 at edge 0 → issue_transmit=1 in cycle after edge 1 with issue_robid=3, issue_depvals[1]=8'h10; pulse lasts one cycle.
- **Wakeup and ordering:** dispatch store robid=1 with A waiting on tag 5, then ready load robid=2 → no issue. Then cdb_valid, id=5, val=8'h20 → store issues with address 8'h20; the load issues on the following cycle.
- **Full:** DEPTH=4, dispatch 4 ops waiting on tag 9 → full=1. A 5th disp_valid is dropped. CDB id=9 releases the 4 ops in order on 4 consecutive cycles, and full falls after the first issue.
- **Same-cycle snoop:** dispatch op with dep tag 7 in the same cycle as cdb_valid id=7 val=8'hAA → op issues normally with operand 8'hAA.
- **Stall then flush:** hold fu_busy=1 with a ready head for 10 cycles → no issue; stall_cnt=10 if MEMQ_STALL_CNT_EN is defined. Assert flush → queue empty, full=0, no issue after fu_busy drops.
- **Reset:** assert rst mid-stream with 3 entries queued → all outputs 0, queue empty the next cycle.
